// File: rtl/acc_share_sched.sv
// Round-robin scheduler that time-shares one external signed accumulator among N_REQ requesters.
// Each job: grant, clear P, stream beats through P+/-A, capture P and hand it out tagged with the id.
module acc_share_sched #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 20,
  parameter int ACC_W  = 38,
  parameter int LEN_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_sub,
  input  logic [N_REQ*LEN_W-1:0]    req_len,
  output logic [N_REQ-1:0]          gnt,
  input  logic [N_REQ-1:0]          in_valid,
  input  logic [N_REQ*DATA_W-1:0]   in_data,
  output logic [N_REQ-1:0]          in_ready,
  output logic [DATA_W-1:0]         acc_a,
  output logic                      acc_subtract,
  output logic                      acc_reset,
  input  logic [ACC_W-1:0]          acc_p,
  output logic                      res_valid,
  output logic [ACC_W-1:0]          res_data,
  output logic [$clog2(N_REQ)-1:0]  res_id,
  input  logic                      res_ready
);

  localparam int ID_W = $clog2(N_REQ);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_RESULT = 3'd4;

  logic [2:0]        state_reg, state_next;
  logic [N_REQ-1:0]  gnt_reg;
  logic [ID_W-1:0]   id_reg;
  logic              sub_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  cnt_reg;
  logic [ID_W-1:0]   ptr_reg;
  logic              res_valid_reg;
  logic [ACC_W-1:0]  res_data_reg;
  logic [ID_W-1:0]   res_id_reg;

  logic [DATA_W-1:0] data_arr [N_REQ];
  logic [LEN_W-1:0]  len_arr  [N_REQ];

  logic              pick_found;
  logic [ID_W-1:0]   pick_id;
  logic              beat_ok;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = in_data[gi*DATA_W +: DATA_W];
      assign len_arr[gi]  = req_len[gi*LEN_W +: LEN_W];
    end
  endgenerate

  // Scan downwards so the requester closest after the pointer is the last (winning) assignment.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req_valid[(int'(ptr_reg) + k) % N_REQ]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'((int'(ptr_reg) + k) % N_REQ);
      end
    end
  end

  assign beat_ok      = (state_reg == ST_RUN) && in_valid[id_reg];
  assign in_ready     = (state_reg == ST_RUN) ? gnt_reg : '0;
  // Only accepted beats reach A, so bubbles leave P untouched.
  assign acc_a        = beat_ok ? data_arr[id_reg] : '0;
  assign acc_subtract = ((state_reg == ST_CLEAR) || (state_reg == ST_RUN) ||
                         (state_reg == ST_DRAIN)) ? sub_reg : 1'b0;
  assign acc_reset    = reset || (state_reg == ST_CLEAR);
  assign gnt          = gnt_reg;
  assign res_valid    = res_valid_reg;
  assign res_data     = res_data_reg;
  assign res_id       = res_id_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (pick_found) state_next = ST_CLEAR;
      ST_CLEAR:  state_next = ST_RUN;
      ST_RUN:    if (beat_ok && (cnt_reg == '0)) state_next = ST_DRAIN;
      ST_DRAIN:  state_next = ST_RESULT;
      ST_RESULT: if (res_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      gnt_reg       <= '0;
      id_reg        <= '0;
      sub_reg       <= 1'b0;
      len_reg       <= '0;
      cnt_reg       <= '0;
      ptr_reg       <= ID_W'(N_REQ - 1);
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_id_reg    <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (pick_found) begin
            gnt_reg <= N_REQ'(1) << pick_id;
            id_reg  <= pick_id;
            sub_reg <= req_sub[pick_id];
            len_reg <= len_arr[pick_id];
          end
        end
        ST_CLEAR: cnt_reg <= len_reg;
        ST_RUN: begin
          if (beat_ok && (cnt_reg != '0)) cnt_reg <= cnt_reg - 1'b1;
        end
        ST_DRAIN: begin
          // P has absorbed the last beat by now.
          res_data_reg  <= acc_p;
          res_id_reg    <= id_reg;
          res_valid_reg <= 1'b1;
        end
        ST_RESULT: begin
          if (res_ready) begin
            res_valid_reg <= 1'b0;
            ptr_reg       <= id_reg;
            gnt_reg       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_share_sched.sv
// Directed and randomized checks of acc_share_sched against a behavioral accumulator.
// Expected sums are computed by the bench from the stimulus it drives.
module tb_acc_share_sched;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 20;
  localparam int ACC_W  = 38;
  localparam int LEN_W  = 8;
  localparam int ID_W   = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_sub;
  logic [N_REQ*LEN_W-1:0]   req_len;
  logic [N_REQ-1:0]         gnt;
  logic [N_REQ-1:0]         in_valid;
  logic [N_REQ*DATA_W-1:0]  in_data;
  logic [N_REQ-1:0]         in_ready;
  logic [DATA_W-1:0]        acc_a;
  logic                     acc_subtract;
  logic                     acc_reset;
  logic [ACC_W-1:0]         acc_p;
  logic                     res_valid;
  logic [ACC_W-1:0]         res_data;
  logic [ID_W-1:0]          res_id;
  logic                     res_ready;

  int n_cmp = 0;
  int n_bad = 0;

  logic signed [DATA_W-1:0] beats [256];
  logic [ACC_W-1:0]         last_res;

  always #5 clk = ~clk;

  acc_share_sched #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_sub(req_sub), .req_len(req_len),
    .gnt(gnt), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .acc_a(acc_a), .acc_subtract(acc_subtract), .acc_reset(acc_reset), .acc_p(acc_p),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready)
  );

  // External accumulator datapath: registered P, sign-extended A, synchronous clear.
  always @(posedge clk) begin
    if (acc_reset)         acc_p <= '0;
    else if (acc_subtract) acc_p <= acc_p - {{(ACC_W-DATA_W){acc_a[DATA_W-1]}}, acc_a};
    else                   acc_p <= acc_p + {{(ACC_W-DATA_W){acc_a[DATA_W-1]}}, acc_a};
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = '0; req_sub = '0; req_len = '0;
    in_valid = '0; in_data = '0; res_ready = 1'b0;
    @(negedge clk);
    chk("acc_reset_in_reset", acc_reset, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_acc_a", acc_a, 0);
    chk("rst_acc_sub", acc_subtract, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_id", res_id, 0);
    @(negedge clk);
  endtask

  // Runs one job from a negedge; bubble: 0 none, 1 alternate, 2 random. hold keeps req_valid up.
  task automatic do_job(input int id, input bit sub, input int len, input int bubble,
                        input int stall, input bit hold);
    longint           sum;
    logic [ACC_W-1:0] exp;
    int               b, cyc, lat;
    bit               acc_ok, tog, first;
    sum = 0;
    for (int i = 0; i <= len; i++) sum = sub ? sum - longint'(beats[i]) : sum + longint'(beats[i]);
    exp = sum[ACC_W-1:0];
    req_valid[id] = 1'b1;
    req_sub[id]   = sub;
    req_len[id*LEN_W +: LEN_W] = LEN_W'(len);
    cyc = 0;
    while (gnt == '0 && cyc < 40) begin @(negedge clk); cyc++; end
    if (cyc >= 40) begin chk("grant_timeout", 0, 1); return; end
    #1;
    chk("gnt", gnt, 64'(1) << id);
    chk("clear_acc_reset", acc_reset, 1);
    chk("clear_in_ready", in_ready, 0);
    if (!hold) req_valid = '0;
    @(negedge clk);
    b = 0; cyc = 0; tog = 1'b1; first = 1'b1;
    while (b <= len && cyc < 4000) begin
      case (bubble)
        0:       in_valid[id] = 1'b1;
        1:       in_valid[id] = tog;
        default: in_valid[id] = 1'($urandom_range(0, 1));
      endcase
      tog = ~tog;
      in_data[id*DATA_W +: DATA_W] = beats[b];
      #1;
      if (first) begin
        chk("first_in_ready", in_ready, 64'(1) << id);
        chk("first_acc_reset", acc_reset, 0);
        first = 1'b0;
      end
      if (!in_valid[id]) chk("bubble_acc_a", acc_a, 0);
      acc_ok = in_valid[id] && in_ready[id];
      @(negedge clk);
      if (acc_ok) b++;
      cyc++;
    end
    in_valid = '0;
    if (cyc >= 4000) chk("stream_timeout", 0, 1);
    lat = 1;
    #1;
    chk("drain_res_valid", res_valid, 0);
    while (!res_valid && lat < 10) begin @(negedge clk); #1; lat++; end
    chk("latency", lat, 2);
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", res_valid, 1);
      chk("stall_data", res_data, exp);
      chk("stall_id", res_id, id);
      @(negedge clk); #1;
    end
    res_ready = 1'b1;
    chk("res_valid", res_valid, 1);
    chk("res_data", res_data, exp);
    chk("res_id", res_id, id);
    last_res = res_data;
    $display("job id=%0d sub=%0d len=%0d res=%0h exp=%0h", id, sub, len, res_data, exp);
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    chk("res_valid_drop", res_valid, 0);
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_sub = '0; req_len = '0;
    in_valid = '0; in_data = '0; res_ready = 1'b0;
    do_reset();

    // Single beat of -1.
    beats[0] = 20'hFFFFF;
    do_job(0, 1'b0, 0, 0, 0, 1'b0);
    chk("t1_minus1", last_res, 38'h3F_FFFF_FFFF);

    // Subtract job: 0-5-10+3-7 = -19.
    beats[0] = 20'sd5; beats[1] = 20'sd10; beats[2] = -20'sd3; beats[3] = 20'sd7;
    do_job(2, 1'b1, 3, 0, 0, 1'b0);
    chk("t2_minus19", last_res, 38'h3F_FFFF_FFED);

    // All four requesting: pointer back at 3, so order 0,1,2,3,0.
    do_reset();
    beats[0] = 20'sd1; beats[1] = 20'sd1;
    req_valid = 4'hF;
    for (int i = 0; i < N_REQ; i++) req_len[i*LEN_W +: LEN_W] = 8'd1;
    do_job(0, 1'b0, 1, 0, 0, 1'b1);
    do_job(1, 1'b0, 1, 0, 0, 1'b1);
    do_job(2, 1'b0, 1, 0, 0, 1'b1);
    do_job(3, 1'b0, 1, 0, 0, 1'b1);
    do_job(0, 1'b0, 1, 0, 0, 1'b0);
    chk("t3_sum2", last_res, 38'd2);

    // Alternating bubbles and a 5-cycle result stall: 3-4+100+7-50+2+9-1 = 66.
    beats[0] = 20'sd3;   beats[1] = -20'sd4; beats[2] = 20'sd100; beats[3] = 20'sd7;
    beats[4] = -20'sd50; beats[5] = 20'sd2;  beats[6] = 20'sd9;   beats[7] = -20'sd1;
    do_job(1, 1'b0, 7, 1, 5, 1'b0);
    chk("t4_sum66", last_res, 38'd66);

    // 256 beats of max positive sample.
    for (int i = 0; i < 256; i++) beats[i] = 20'sh7FFFF;
    do_job(3, 1'b0, 255, 0, 0, 1'b0);
    chk("t5_max", last_res, 38'd134217472);

    // Reset after 100 accepted beats of a new job.
    req_valid[0] = 1'b1; req_sub[0] = 1'b0; req_len[0 +: LEN_W] = 8'd255;
    @(negedge clk); @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      in_valid[0] = 1'b1; in_data[0 +: DATA_W] = 20'sh7FFFF;
      @(negedge clk);
    end
    in_valid = '0;
    reset = 1'b1;
    #1;
    chk("midjob_acc_reset", acc_reset, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midjob_gnt", gnt, 0);
    chk("midjob_in_ready", in_ready, 0);
    chk("midjob_res_valid", res_valid, 0);
    chk("midjob_p", acc_p, 0);
    @(negedge clk);
    beats[0] = 20'sd4; beats[1] = 20'sd5; beats[2] = 20'sd6;
    do_job(1, 1'b0, 2, 0, 0, 1'b0);
    chk("t5_after_reset", last_res, 38'd15);

    // Random regression.
    for (int j = 0; j < 1000; j++) begin
      int id, len, bub, stall;
      bit sub;
      id    = $urandom_range(0, N_REQ-1);
      sub   = 1'($urandom_range(0, 1));
      len   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 60) : $urandom_range(0, 12);
      bub   = ($urandom_range(0, 2) == 0) ? 2 : 0;
      stall = $urandom_range(0, 3);
      for (int i = 0; i <= len; i++) beats[i] = DATA_W'($urandom);
      do_job(id, sub, len, bub, stall, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
